// File: rtl/conv1d_seq_pkg.sv
// ----------------------------------------------------------------------------
// conv1d_seq_pkg
// Shared definitions for the conv1d command sequencer:
//   - seq_state_e   : sequencer FSM states
//   - *_DFLT        : default funct7 codes for the burst / status macro-commands
//                     and the per-step datapath command issued during a burst
//   - TIMEOUT_RSP   : response word returned when a datapath op times out
//   - status_word() : packs the sticky timeout flag into a response word
// ----------------------------------------------------------------------------
package conv1d_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } seq_state_e;

  localparam logic [6:0]  BURST_FUNCT_DFLT   = 7'h7F;
  localparam logic [6:0]  STATUS_FUNCT_DFLT  = 7'h7E;
  localparam logic [6:0]  BURST_SUB_CMD_DFLT = 7'h01;
  localparam logic [31:0] TIMEOUT_RSP        = 32'hFFFF_FFFF;

  // Status response: bit 0 carries the sticky timeout flag, all else zero.
  function automatic logic [31:0] status_word(input logic err);
    return {31'd0, err};
  endfunction

endpackage

// File: rtl/conv1d_seq_timeout.sv
// ----------------------------------------------------------------------------
// conv1d_seq_timeout
// Clearable, enabled cycle counter used to bound the wait for a datapath
// result. The count saturates at TIMEOUT_CYCLES-1 and o_expired is high
// while it sits there.
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset
//   i_clr      : synchronous clear (wins over i_en)
//   i_en       : count enable
//   o_expired  : count has reached TIMEOUT_CYCLES-1
// ----------------------------------------------------------------------------
module conv1d_seq_timeout #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int            CW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // Wait-cycle counter: cleared on issue, counts while waiting, saturates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= {CW{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {CW{1'b0}};
    end else if (i_en && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/conv1d_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// conv1d_cmd_sequencer
// Bridges the CPU CFU command/response bus to the conv1d datapath. A plain
// command is forwarded to the datapath as a one-cycle dp_issue strobe; the
// result (or a timeout marker) is held on the response bus until the CPU
// takes it. funct7==BURST_FUNCT runs N datapath steps (dp_inp0 = 0..N-1)
// from one instruction; funct7==STATUS_FUNCT returns and clears the sticky
// timeout flag.
// Ports:
//   clk, reset                       : clock / async active-low reset
//   cmd_valid, cmd_ready             : command handshake (ready only in IDLE)
//   cmd_payload_function_id[9:3]     : funct7 ([2:0] funct3 is ignored)
//   cmd_payload_inputs_0/1           : operands
//   rsp_valid, rsp_ready             : response handshake
//   rsp_payload_outputs_0            : registered response word
//   dp_cmd, dp_inp0, dp_inp1         : registered datapath command/operands
//   dp_issue                         : one-cycle start strobe
//   dp_ret, dp_valid                 : datapath result / result valid
//   busy                             : sequencer not idle
//   timeout_err                      : sticky datapath timeout flag
// ----------------------------------------------------------------------------
module conv1d_cmd_sequencer
  import conv1d_seq_pkg::*;
#(
  parameter logic [6:0] BURST_FUNCT    = BURST_FUNCT_DFLT,
  parameter logic [6:0] STATUS_FUNCT   = STATUS_FUNCT_DFLT,
  parameter logic [6:0] BURST_SUB_CMD  = BURST_SUB_CMD_DFLT,
  parameter int         TIMEOUT_CYCLES = 256,
  parameter int         CNT_W          = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0,
  output logic [6:0]  dp_cmd,
  output logic [31:0] dp_inp0,
  output logic [31:0] dp_inp1,
  output logic        dp_issue,
  input  logic [31:0] dp_ret,
  input  logic        dp_valid,
  output logic        busy,
  output logic        timeout_err
);

  seq_state_e       r_state;
  logic             r_rsp_valid;
  logic [31:0]      r_rsp_payload;
  logic [6:0]       r_dp_cmd;
  logic [31:0]      r_dp_inp0;
  logic [31:0]      r_dp_inp1;
  logic             r_dp_issue;
  logic             r_timeout_err;
  logic [CNT_W-1:0] r_remaining;

  logic [6:0]       w_funct7;
  logic [CNT_W-1:0] w_burst_n;
  logic             w_accept;
  logic             w_to_clr;
  logic             w_to_en;
  logic             w_expired;
  logic [2:0]       w_unused_funct3;

  assign w_funct7        = cmd_payload_function_id[9:3];
  assign w_unused_funct3 = cmd_payload_function_id[2:0];
  assign w_burst_n       = cmd_payload_inputs_0[CNT_W-1:0];
  assign w_accept        = cmd_valid && (r_state == ST_IDLE);

  // The counter restarts on every issue and only runs while waiting.
  assign w_to_clr = (r_state == ST_ISSUE);
  assign w_to_en  = (r_state == ST_WAIT);

  conv1d_seq_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_to_clr),
    .i_en      (w_to_en),
    .o_expired (w_expired)
  );

  // Sequencer FSM with all bus/datapath outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_rsp_valid   <= 1'b0;
      r_rsp_payload <= 32'd0;
      r_dp_cmd      <= 7'd0;
      r_dp_inp0     <= 32'd0;
      r_dp_inp1     <= 32'd0;
      r_dp_issue    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_remaining   <= {CNT_W{1'b0}};
    end else begin
      // dp_issue is a strobe: only the transitions into ISSUE raise it.
      r_dp_issue <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_funct7 == STATUS_FUNCT) begin
              r_rsp_payload <= status_word(r_timeout_err);
              r_timeout_err <= 1'b0;
              r_rsp_valid   <= 1'b1;
              r_state       <= ST_RESP;
            end else if (w_funct7 == BURST_FUNCT) begin
              if (w_burst_n == {CNT_W{1'b0}}) begin
                r_rsp_payload <= 32'd0;
                r_rsp_valid   <= 1'b1;
                r_state       <= ST_RESP;
              end else begin
                r_dp_cmd    <= BURST_SUB_CMD;
                r_dp_inp0   <= 32'd0;
                r_dp_inp1   <= cmd_payload_inputs_1;
                r_remaining <= w_burst_n;
                r_dp_issue  <= 1'b1;
                r_state     <= ST_ISSUE;
              end
            end else begin
              r_dp_cmd    <= w_funct7;
              r_dp_inp0   <= cmd_payload_inputs_0;
              r_dp_inp1   <= cmd_payload_inputs_1;
              r_remaining <= CNT_W'(1);
              r_dp_issue  <= 1'b1;
              r_state     <= ST_ISSUE;
            end
          end
        end

        ST_ISSUE, ST_WAIT: begin
          // A result in the same cycle as the timeout still counts.
          if (dp_valid) begin
            r_rsp_payload <= dp_ret;
            r_remaining   <= r_remaining - CNT_W'(1);
            if (r_remaining == CNT_W'(1)) begin
              r_rsp_valid <= 1'b1;
              r_state     <= ST_RESP;
            end else begin
              r_dp_inp0  <= r_dp_inp0 + 32'd1;
              r_dp_issue <= 1'b1;
              r_state    <= ST_ISSUE;
            end
          end else if ((r_state == ST_WAIT) && w_expired) begin
            // Abandon any remaining burst steps.
            r_rsp_payload <= TIMEOUT_RSP;
            r_timeout_err <= 1'b1;
            r_remaining   <= {CNT_W{1'b0}};
            r_rsp_valid   <= 1'b1;
            r_state       <= ST_RESP;
          end else begin
            r_state <= ST_WAIT;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready             = (r_state == ST_IDLE);
  assign busy                  = (r_state != ST_IDLE);
  assign rsp_valid             = r_rsp_valid;
  assign rsp_payload_outputs_0 = r_rsp_payload;
  assign dp_cmd                = r_dp_cmd;
  assign dp_inp0               = r_dp_inp0;
  assign dp_inp1               = r_dp_inp1;
  assign dp_issue              = r_dp_issue;
  assign timeout_err           = r_timeout_err;

endmodule

// File: tb/tb_conv1d_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// tb_conv1d_cmd_sequencer
// Drives CFU commands into conv1d_cmd_sequencer and emulates the datapath.
// Each datapath op answers dp_inp0+dp_inp1 after a per-op delay taken from a
// plan (0 = in the issue cycle, -1 = never). A command-level model predicts
// the issued op list, the response word, the latency and the sticky flag.
// ----------------------------------------------------------------------------
module tb_conv1d_cmd_sequencer;

  localparam int TO = 8;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;
  logic [6:0]  dp_cmd;
  logic [31:0] dp_inp0;
  logic [31:0] dp_inp1;
  logic        dp_issue;
  logic [31:0] dp_ret;
  logic        dp_valid;
  logic        busy;
  logic        timeout_err;

  int checks;
  int failures;

  int          plan_q[$];
  int          resp_q[$];
  logic [70:0] log_q[$];
  int          countdown;
  int          rd;
  logic        stray_valid;
  logic        model_err;

  conv1d_cmd_sequencer #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (cmd_payload_function_id),
    .cmd_payload_inputs_0    (cmd_payload_inputs_0),
    .cmd_payload_inputs_1    (cmd_payload_inputs_1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_payload_outputs_0),
    .dp_cmd                  (dp_cmd),
    .dp_inp0                 (dp_inp0),
    .dp_inp1                 (dp_inp1),
    .dp_issue                (dp_issue),
    .dp_ret                  (dp_ret),
    .dp_valid                (dp_valid),
    .busy                    (busy),
    .timeout_err             (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Datapath emulation and issue log, updated away from the rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      countdown = 0;
      dp_valid  = stray_valid;
    end else if (dp_issue) begin
      log_q.push_back({dp_cmd, dp_inp0, dp_inp1});
      rd = 0;
      if (resp_q.size() > 0) rd = resp_q.pop_front();
      if (rd == 0) begin
        countdown = 0;
        dp_valid  = 1'b1;
      end else begin
        countdown = (rd < 0) ? 0 : rd;
        dp_valid  = stray_valid;
      end
    end else if (countdown > 0) begin
      countdown = countdown - 1;
      dp_valid  = (countdown == 0) | stray_valid;
    end else begin
      dp_valid = stray_valid;
    end
    dp_ret = dp_inp0 + dp_inp1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one command end to end; plan_q holds the per-op datapath delays.
  task automatic run_cmd(input logic [6:0] f7, input logic [31:0] in0,
                         input logic [31:0] in1, input int hold);
    logic [70:0] exp_ops[$];
    logic [31:0] exp_rsp;
    int          exp_lat;
    bit          lat_known;
    int          n_ops;
    int          d;
    int          edges;

    // Command-level model: edges counted from the accept edge inclusive.
    exp_rsp   = 32'd0;
    exp_lat   = 1;
    lat_known = 1'b1;
    if (f7 == 7'h7E) begin
      exp_rsp   = {31'd0, model_err};
      model_err = 1'b0;
    end else begin
      n_ops = (f7 == 7'h7F) ? int'(in0[15:0]) : 1;
      for (int k = 0; k < n_ops; k++) begin
        if (f7 == 7'h7F) exp_ops.push_back({7'h01, 32'(k), in1});
        else             exp_ops.push_back({f7, in0, in1});
        d = (k < plan_q.size()) ? plan_q[k] : 0;
        if (d < 0 || d > TO) begin
          exp_rsp   = 32'hFFFF_FFFF;
          model_err = 1'b1;
          lat_known = 1'b0;
          break;
        end
        exp_rsp = (f7 == 7'h7F) ? (32'(k) + in1) : (in0 + in1);
        exp_lat = exp_lat + d + 1;
      end
    end

    resp_q = plan_q;
    log_q.delete();

    @(negedge clk);
    check_eq("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid               = 1'b1;
    cmd_payload_function_id = {f7, 3'($urandom_range(0, 7))};
    cmd_payload_inputs_0    = in0;
    cmd_payload_inputs_1    = in1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    cmd_valid            = 1'b0;
    cmd_payload_inputs_0 = $urandom;
    cmd_payload_inputs_1 = $urandom;
    while (rsp_valid !== 1'b1 && edges < 400) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check_eq("rsp_valid", 64'(rsp_valid), 64'd1);
    if (lat_known) check_eq("latency", 64'(edges), 64'(exp_lat));
    check_eq("rsp_payload", 64'(rsp_payload_outputs_0), 64'(exp_rsp));
    check_eq("busy_resp", 64'(busy), 64'd1);

    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("rsp_hold_valid", 64'(rsp_valid), 64'd1);
      check_eq("rsp_hold_payload", 64'(rsp_payload_outputs_0), 64'(exp_rsp));
      check_eq("cmd_ready_hold", 64'(cmd_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("rsp_valid_drop", 64'(rsp_valid), 64'd0);
    check_eq("cmd_ready_back", 64'(cmd_ready), 64'd1);
    check_eq("busy_idle", 64'(busy), 64'd0);

    check_eq("issue_count", 64'(log_q.size()), 64'(exp_ops.size()));
    for (int i = 0; i < exp_ops.size() && i < log_q.size(); i++) begin
      check_eq("issue_inp0", 64'(log_q[i][63:32]), 64'(exp_ops[i][63:32]));
      check_eq("issue_cmd_inp1", 64'({log_q[i][70:64], log_q[i][31:0]}),
               64'({exp_ops[i][70:64], exp_ops[i][31:0]}));
    end
    check_eq("timeout_err", 64'(timeout_err), 64'(model_err));
  endtask

  initial begin
    int kind;
    int n;
    logic [6:0] f7;

    checks                  = 0;
    failures                = 0;
    model_err               = 1'b0;
    stray_valid             = 1'b0;
    countdown               = 0;
    reset                   = 1'b0;
    cmd_valid               = 1'b0;
    rsp_ready               = 1'b0;
    cmd_payload_function_id = 10'd0;
    cmd_payload_inputs_0    = 32'd0;
    cmd_payload_inputs_1    = 32'd0;
    repeat (3) @(negedge clk);

    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_rsp_payload", 64'(rsp_payload_outputs_0), 64'd0);
    check_eq("rst_dp_issue", 64'(dp_issue), 64'd0);
    check_eq("rst_dp_regs", 64'({dp_cmd, dp_inp0} | 64'(dp_inp1)), 64'd0);
    check_eq("rst_timeout_err", 64'(timeout_err), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    reset = 1'b1;

    // Pass-through, result in the issue cycle.
    plan_q = '{0};
    run_cmd(7'h03, 32'd5, 32'd7, 0);
    // Delayed datapath (4 cycles after issue), response held 3 cycles.
    plan_q = '{4};
    run_cmd(7'h22, 32'h0000_AB00, 32'h0000_00CD, 3);
    // Burst of 4, immediate datapath; then empty burst.
    plan_q = '{0, 0, 0, 0};
    run_cmd(7'h7F, 32'd4, 32'h10, 1);
    plan_q = '{};
    run_cmd(7'h7F, 32'hABCD_0000, 32'h55, 0);
    // Timeout, then status reads 1 and clears, then 0.
    plan_q = '{-1};
    run_cmd(7'h05, 32'd1, 32'd2, 0);
    plan_q = '{};
    run_cmd(7'h7E, 32'd0, 32'd0, 0);
    run_cmd(7'h7E, 32'd0, 32'd0, 1);
    // Burst abort on the second step.
    plan_q = '{0, -1, 0};
    run_cmd(7'h7F, 32'd3, 32'h100, 0);
    plan_q = '{};
    run_cmd(7'h7E, 32'd0, 32'd0, 0);

    // Stray dp_valid while idle must be ignored.
    @(negedge clk);
    stray_valid = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("stray_busy", 64'(busy), 64'd0);
    check_eq("stray_rsp_valid", 64'(rsp_valid), 64'd0);
    stray_valid = 1'b0;

    // Reset while waiting on the datapath.
    plan_q = '{-1};
    resp_q = plan_q;
    @(negedge clk);
    cmd_valid               = 1'b1;
    cmd_payload_function_id = {7'h09, 3'd0};
    cmd_payload_inputs_0    = 32'd3;
    cmd_payload_inputs_1    = 32'd4;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("pre_reset_busy", 64'(busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    check_eq("mid_rst_dp_issue", 64'(dp_issue), 64'd0);
    check_eq("mid_rst_timeout_err", 64'(timeout_err), 64'd0);
    model_err = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    plan_q = '{1};
    run_cmd(7'h03, 32'd20, 32'd22, 0);

    // Randomized mix of commands and datapath delays.
    for (int it = 0; it < 30; it++) begin
      kind = $urandom_range(0, 9);
      plan_q = '{};
      for (int k = 0; k < 6; k++) begin
        if ($urandom_range(0, 9) == 0) plan_q.push_back(-1);
        else                           plan_q.push_back(int'($urandom_range(0, 3)));
      end
      if (kind < 5) begin
        f7 = 7'($urandom_range(0, 125));
        run_cmd(f7, $urandom, $urandom, int'($urandom_range(0, 2)));
      end else if (kind < 8) begin
        n = int'($urandom_range(0, 5));
        run_cmd(7'h7F, {16'($urandom), 16'(n)}, $urandom, int'($urandom_range(0, 2)));
      end else begin
        run_cmd(7'h7E, $urandom, $urandom, int'($urandom_range(0, 2)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
